// File: rtl/mul_sched.sv
// mul_sched: round-robin sequencer that shares one seq_mul shift-add
// multiplier between two RV32M requesters (MUL/MULH/MULHSU/MULHU).
// Signed ops are reduced to an unsigned magnitude multiply, and the sign
// is restored on capture.
// Optional feature: define MUL_SCHED_ZERO_BYPASS_EN to answer zero-operand
// requests directly, without using the multiplier.
module mul_sched #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_op0,
  input  logic [1:0]      req_op1,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_b0,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy,
  output logic            mul_L,
  output logic [63:0]     mul_a,
  output logic [63:0]     mul_b,
  input  logic [64:0]     mul_y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic              last_q;
  logic              id_q;
  logic              neg_q;
  logic              hi_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mul_L_q;
  logic [63:0]       mul_a_q;
  logic [63:0]       mul_b_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [XLEN-1:0]   rsp_data_q;

  logic              gnt_id;
  logic              accept;
  logic [1:0]        sel_op;
  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;
  logic              a_sgn;
  logic              b_sgn;
  logic [XLEN-1:0]   mag_a_d;
  logic [XLEN-1:0]   mag_b_d;
  logic              neg_d;
  logic              hi_d;
  logic [63:0]       prod_p;
  logic              unused_y;

  assign unused_y = mul_y[64];

  // Round-robin grant; ready is offered only in IDLE and never during reset
  always_comb begin
    gnt_id = 1'b0;
    case (req_valid)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
    req_ready = '0;
    if (state_q == S_IDLE && Rst && |req_valid) begin
      req_ready = gnt_id ? 2'b10 : 2'b01;
    end
    accept = |(req_valid & req_ready);
  end

  // Granted operands reduced to unsigned magnitudes plus a result sign
  always_comb begin
    sel_op  = gnt_id ? req_op1 : req_op0;
    sel_a   = gnt_id ? req_a1  : req_a0;
    sel_b   = gnt_id ? req_b1  : req_b0;
    a_sgn   = (sel_op == 2'b01 || sel_op == 2'b10) && sel_a[XLEN-1];
    b_sgn   = (sel_op == 2'b01) && sel_b[XLEN-1];
    mag_a_d = a_sgn ? (~sel_a + XLEN'(1)) : sel_a;
    mag_b_d = b_sgn ? (~sel_b + XLEN'(1)) : sel_b;
    neg_d   = a_sgn ^ b_sgn;
    hi_d    = (sel_op != 2'b00);
  end

  // Sign-corrected 64-bit product
  always_comb begin
    prod_p = neg_q ? (~mul_y[63:0] + 64'd1) : mul_y[63:0];
  end

  // Sequencer FSM: accept, load, count multiplier latency, capture, respond
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      neg_q       <= 1'b0;
      hi_q        <= 1'b0;
      cnt_q       <= '0;
      mul_L_q     <= 1'b1;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mul_L_q <= 1'b1;
          if (accept) begin
            last_q <= gnt_id;
            id_q   <= gnt_id;
            neg_q  <= neg_d;
            hi_q   <= hi_d;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
            if (mag_a_d == '0 || mag_b_d == '0) begin
              rsp_data_q  <= '0;
              rsp_id_q    <= gnt_id;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              mul_a_q <= {{(64-XLEN){1'b0}}, mag_a_d};
              mul_b_q <= {{(64-XLEN){1'b0}}, mag_b_d};
              state_q <= S_LOAD;
            end
`else
            mul_a_q <= {{(64-XLEN){1'b0}}, mag_a_d};
            mul_b_q <= {{(64-XLEN){1'b0}}, mag_b_d};
            state_q <= S_LOAD;
`endif
          end
        end
        S_LOAD: begin
          mul_L_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            state_q <= S_CAPT;
          end
        end
        S_CAPT: begin
          rsp_data_q  <= hi_q ? prod_p[2*XLEN-1:XLEN] : prod_p[XLEN-1:0];
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          mul_L_q     <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mul_L     = mul_L_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: scoreboard bench for mul_sched with a behavioural
// shift-add multiplier standing in for seq_mul.
module tb_mul_sched;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        busy;
  logic        mul_L;
  logic [63:0] mul_a, mul_b;
  logic [64:0] mul_y;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  mul_sched #(.XLEN(32), .MUL_LAT(64), .CNT_W(7)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy),
    .mul_L(mul_L), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural seq_mul: load on L=1, one shift-add step per L=0 edge
  logic [64:0] m_acc = '0;
  logic [63:0] m_a   = '0;
  logic [63:0] m_b   = '0;
  int unsigned m_k   = 0;
  always @(posedge Clk) begin
    if (mul_L) begin
      m_acc <= '0;
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_k   <= 0;
    end else if (m_k < 64) begin
      if (m_b[m_k]) m_acc <= m_acc + ({1'b0, m_a} << m_k);
      m_k <= m_k + 1;
    end
  end
  assign mul_y = m_acc;

  // Reference RV32M result from two's complement 64-bit arithmetic
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, pr;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    pr = xa * xb;
    return (op == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  function automatic logic [63:0] ref_mag(input logic sgn, input logic [31:0] v);
    logic [31:0] m;
    m = (sgn && v[31]) ? (32'h0 - v) : v;
    return {32'h0, m};
  endfunction

  task automatic apply_reset();
    @(negedge Clk);
    Rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    sb_q.delete();
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
    req_valid[id] = 1'b1;
  endtask

  // Holds a request until accepted; returns at the negedge after the accept edge
  task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned acc_cyc, output bit ok);
    exp_t e;
    ok = 1'b0;
    acc_cyc = 0;
    drive_req(id, op, a, b);
    for (int i = 0; i < 300; i++) begin
      #1;
      if (req_ready[id]) begin
        acc_cyc = cyc;
        e.id = id; e.data = ref_mul(op, a, b);
        sb_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        req_valid[id] = 1'b0;
        drive_req(id, ~op, ~a, b ^ 32'h5A5A_0000);
        req_valid[id] = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL issue_timeout id=%0d got no grant, required grant within 300 cycles", id);
    end
  endtask

  task automatic wait_rsp(output bit got, output int unsigned rcyc, output logic id, output logic [31:0] data);
    got = 1'b0; rcyc = 0; id = 1'b0; data = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (rsp_valid) begin
        got = 1'b1; rcyc = cyc; id = rsp_id; data = rsp_data;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b0; rsp_ready = 1'b0;
    drive_req(1'b0, 2'b00, 32'd3, 32'd4);
    drive_req(1'b1, 2'b00, 32'd5, 32'd6);
    @(negedge Clk);
    #1;
    checks++;
    if (req_ready !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b busy=%b rsp_valid=%b, required 00/0/0", req_ready, busy, rsp_valid);
    end
    checks++;
    if (mul_L !== 1'b1 || mul_a !== 64'h0 || mul_b !== 64'h0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_data mul_L=%b a=%h b=%h data=%h id=%b, required 1/0/0/0/0", mul_L, mul_a, mul_b, rsp_data, rsp_id);
    end
    req_valid = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_arith();
    logic [1:0]  t_op [9];
    logic [31:0] t_a  [9];
    logic [31:0] t_b  [9];
    logic        t_id [9];
    int unsigned acc, rc;
    bit ok, got;
    logic gid;
    logic [31:0] gd;
    exp_t e;
    t_id[0] = 0; t_op[0] = 2'b11; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF;
    t_id[1] = 1; t_op[1] = 2'b00; t_a[1] = 32'd7;         t_b[1] = 32'hFFFF_FFFD;
    t_id[2] = 1; t_op[2] = 2'b01; t_a[2] = 32'd7;         t_b[2] = 32'hFFFF_FFFD;
    t_id[3] = 0; t_op[3] = 2'b01; t_a[3] = 32'h8000_0000; t_b[3] = 32'h8000_0000;
    t_id[4] = 1; t_op[4] = 2'b10; t_a[4] = 32'hFFFF_FFFF; t_b[4] = 32'hFFFF_FFFF;
    t_id[5] = 0; t_op[5] = 2'b10; t_a[5] = 32'h8000_0000; t_b[5] = 32'h7FFF_FFFF;
    for (int unsigned i = 6; i < 9; i++) begin
      t_id[i] = 1'($urandom_range(1));
      t_op[i] = 2'($urandom_range(3));
      t_a[i]  = $urandom | 32'h1;
      t_b[i]  = $urandom | 32'h1;
    end
    for (int unsigned i = 0; i < 9; i++) begin
      @(negedge Clk);
      issue(t_id[i], t_op[i], t_a[i], t_b[i], acc, ok);
      if (!ok) continue;
      checks++;
      if (mul_L !== 1'b1 || mul_a !== ref_mag(t_op[i] == 2'b01 || t_op[i] == 2'b10, t_a[i])
          || mul_b !== ref_mag(t_op[i] == 2'b01, t_b[i])) begin
        failures++;
        $display("FAIL load_%0d mul_L=%b a=%h b=%h, required 1 a=%h b=%h", i, mul_L, mul_a, mul_b,
                 ref_mag(t_op[i] == 2'b01 || t_op[i] == 2'b10, t_a[i]), ref_mag(t_op[i] == 2'b01, t_b[i]));
      end
      @(negedge Clk);
      #1;
      checks++;
      if (mul_L !== 1'b0) begin
        failures++;
        $display("FAIL run_L_%0d mul_L=%b, required 0", i, mul_L);
      end
      wait_rsp(got, rc, gid, gd);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rsp_timeout_%0d no rsp_valid, required response", i);
      end else begin
        if (gd !== e.data || gid !== e.id) begin
          failures++;
          $display("FAIL result_%0d data=%h id=%b, required data=%h id=%b", i, gd, gid, e.data, e.id);
        end
        // measured from the accept cycle to the first RESP cycle
        checks++;
        if (rc - acc !== 67) begin
          failures++;
          $display("FAIL latency_%0d got %0d cycles, required 67", i, rc - acc);
        end
        release_rsp();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL release_%0d rsp_valid=%b busy=%b, required 0/0", i, rsp_valid, busy);
        end
      end
    end
  endtask

  task automatic test_hold();
    int unsigned acc, rc;
    bit ok, got;
    logic gid;
    logic [31:0] gd;
    exp_t e;
    bit bad;
    @(negedge Clk);
    issue(1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, acc, ok);
    if (!ok) return;
    drive_req(1'b1, 2'b11, 32'h1234, 32'h5678);
    wait_rsp(got, rc, gid, gd);
    e = sb_q.pop_front();
    bad = !got;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge Clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== gd || rsp_id !== gid || req_ready !== 2'b00 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_stable valid=%b data=%h ready=%b busy=%b, required 1/%h/00/1", rsp_valid, rsp_data, req_ready, busy, gd);
    end
    checks++;
    if (gd !== e.data || gid !== e.id) begin
      failures++;
      $display("FAIL hold_result data=%h id=%b, required %h/%b", gd, gid, e.data, e.id);
    end
    req_valid = 2'b00;
    release_rsp();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic g_ord [3];
    int unsigned g_cyc [3];
    int unsigned ng, nr;
    bit bad_hot, bad_busy;
    exp_t e;
    apply_reset();
    drive_req(1'b0, 2'b01, 32'hFFFF_FFFB, 32'd7);
    drive_req(1'b1, 2'b11, 32'hFFFF_FFFF, 32'd2);
    rsp_ready = 1'b1;
    ng = 0; nr = 0; bad_hot = 0; bad_busy = 0;
    for (int unsigned i = 0; i < 400 && nr < 3; i++) begin
      #1;
      if (req_ready == 2'b11) bad_hot = 1'b1;
      if (req_ready != 2'b00 && busy) bad_busy = 1'b1;
      if (req_ready != 2'b00 && ng < 3) begin
        g_ord[ng] = req_ready[1];
        g_cyc[ng] = cyc;
        e.id = req_ready[1];
        e.data = req_ready[1] ? ref_mul(req_op1, req_a1, req_b1) : ref_mul(req_op0, req_a0, req_b0);
        sb_q.push_back(e);
        ng++;
      end
      if (rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected rsp data=%h id=%b, required no response", rsp_data, rsp_id);
        end else begin
          e = sb_q.pop_front();
          if (rsp_data !== e.data || rsp_id !== e.id) begin
            failures++;
            $display("FAIL b2b_result_%0d data=%h id=%b, required %h/%b", nr, rsp_data, rsp_id, e.data, e.id);
          end
        end
        nr++;
        if (nr == 3) req_valid = 2'b00;
      end
      @(negedge Clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (ng != 3 || nr != 3) begin
      failures++;
      $display("FAIL b2b_count grants=%0d rsps=%0d, required 3/3", ng, nr);
    end else begin
      checks++;
      if (g_ord[0] !== 1'b0 || g_ord[1] !== 1'b1 || g_ord[2] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_order got %b%b%b, required 010", g_ord[0], g_ord[1], g_ord[2]);
      end
      checks++;
      if (g_cyc[1] - g_cyc[0] != 68 || g_cyc[2] - g_cyc[1] != 68) begin
        failures++;
        $display("FAIL b2b_spacing got %0d/%0d cycles, required 68/68", g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1]);
      end
    end
    checks++;
    if (bad_hot || bad_busy) begin
      failures++;
      $display("FAIL b2b_ready two_hot=%b grant_while_busy=%b, required 0/0", bad_hot, bad_busy);
    end
  endtask

  task automatic test_reset_abort();
    int unsigned acc, rc;
    bit ok, got, saw;
    logic gid;
    logic [31:0] gd;
    exp_t e;
    @(negedge Clk);
    issue(1'b1, 2'b00, 32'd9, 32'd9, acc, ok);
    if (!ok) return;
    void'(sb_q.pop_back());
    repeat (20) @(negedge Clk);
    drive_req(1'b0, 2'b00, 32'd1, 32'd1);
    Rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mul_L !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL abort_state busy=%b mul_L=%b rsp_valid=%b ready=%b, required 0/1/0/00", busy, mul_L, rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    rsp_ready = 1'b1;
    saw = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      #1;
      if (rsp_valid || !mul_L) saw = 1'b1;
      @(negedge Clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL abort_norsp response or unparked multiplier after abort, required none");
    end
    issue(1'b0, 2'b00, 32'd3, 32'd5, acc, ok);
    if (!ok) return;
    wait_rsp(got, rc, gid, gd);
    e = sb_q.pop_front();
    checks++;
    if (!got || gd !== e.data || gd !== 32'd15 || gid !== 1'b0) begin
      failures++;
      $display("FAIL abort_next got=%b data=%h id=%b, required 1/0000000f/0", got, gd, gid);
    end
    if (got) release_rsp();
  endtask

  task automatic test_zero();
    int unsigned acc, rc, lows;
    bit ok, got;
    logic [31:0] gd;
    exp_t e;
    @(negedge Clk);
    issue(1'b0, 2'b00, 32'd0, 32'd123, acc, ok);
    if (!ok) return;
    got = 1'b0; lows = 0; rc = 0; gd = '1;
    for (int unsigned i = 0; i < 300; i++) begin
      #1;
      if (rsp_valid) begin got = 1'b1; rc = cyc; gd = rsp_data; break; end
      if (!mul_L) lows++;
      @(negedge Clk);
    end
    e = sb_q.pop_front();
    checks++;
    if (!got || gd !== e.data) begin
      failures++;
      $display("FAIL zero_result got=%b data=%h, required 1/%h", got, gd, e.data);
    end
`ifdef MUL_SCHED_ZERO_BYPASS_EN
    checks++;
    if (rc - acc !== 1 || lows != 0) begin
      failures++;
      $display("FAIL zero_bypass latency=%0d mul_L_low_cycles=%0d, required 1/0", rc - acc, lows);
    end
`else
    checks++;
    if (rc - acc !== 67) begin
      failures++;
      $display("FAIL zero_latency got %0d cycles, required 67", rc - acc);
    end
`endif
    if (got) release_rsp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    test_reset();
    test_arith();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Sequencer and round-robin arbiter that shares one `seq_mul` 64-bit unsigned shift-add multiplier between two RV32M requesters, e.g. the EX stage and a divide/fix-up helper.
- Converts MUL/MULH/MULHSU/MULHU into an unsigned magnitude multiply.
- Drives the multiplier's load/operand ports and counts its fixed iteration latency, since the multiplier has no done flag.
- Applies the sign correction and returns a 32-bit result with the requester ID.

Parameters:
- `XLEN`, 32, operand/result width. Operands are zero-extended to 64 bits on `mul_a` and `mul_b`.
- `MUL_LAT`, 64, number of multiplier compute edges (`L`=0) before `mul_y` holds the product.
- `CNT_W`, 7, width of the iteration counter. Must satisfy 2^`CNT_W` > `MUL_LAT`.

Ports:
- `Clk`  in  1  clock
- `Rst`  in  1  asynchronous active-low reset
- `req_valid`  in  2  per-requester request valid
- `req_ready`  out  2  per-requester accept; one-hot or zero
- `req_op0`, `req_op1`  in  2 each  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  `XLEN` each  rs1/rs2 operands
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  requester index of the result
- `rsp_data`  out  `XLEN`  result
- `busy`  out  1  high in any state other than IDLE
- `mul_L`  out  1  load strobe to the multiplier
- `mul_a`, `mul_b`  out  64 each  multiplicand/multiplier to the multiplier
- `mul_y`  in  65  multiplier product; bits [63:0] are used

Behaviour:
- Reset (`Rst`=0, asynchronous):
  - state=IDLE, `mul_L`=1, `mul_a`=`mul_b`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.
  - `req_ready` forced to 0 while `Rst`=0.
  - Last-grant pointer=1, so requester 0 wins first.
- States: IDLE -> LOAD -> RUN -> CAPT -> RESP -> IDLE.
- IDLE:
  - `mul_L`=1, which keeps the multiplier parked.
  - `req_ready` is combinational and goes to the granted requester only.
  - Grant rule: a single valid requester wins. If both are valid, the requester not granted last wins.
  - Accept edge (`req_valid[i]` & `req_ready[i]`):
    - Latch `|a|` and `|b|` per op signedness: MULH both signed; MULHSU a signed, b unsigned; MUL and MULHU unsigned.
    - Latch neg = sign(a) XOR sign(b) over the signed operands.
    - Latch hi = (op!=00), the id, and update the last-grant pointer.
    - Go to LOAD.
  - |-2^31| = 0x80000000 (unsigned) is legal.
- LOAD: `mul_L`=1 with the latched magnitudes on `mul_a`/`mul_b` for exactly one cycle; counter cleared; go to RUN.
- RUN:
  - `mul_L`=0; counter increments every edge.
  - When counter==`MUL_LAT`-1, go to CAPT. That is exactly `MUL_LAT` RUN cycles.
- CAPT:
  - p = neg ? (~`mul_y`[63:0] + 1) : `mul_y`[63:0], modulo 2^64.
  - `rsp_data` <= hi ? p[63:32] : p[31:0]; `rsp_id` <= latched id.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_id` are stable.
  - On `rsp_ready`, go to IDLE; `rsp_valid` drops on that edge.
  - `rsp_ready` low holds RESP indefinitely.
- Latency: `rsp_valid` rises `MUL_LAT`+3 cycles after the accept edge (67 by default).
- Throughput: one op per `MUL_LAT`+4 cycles minimum, including the IDLE accept cycle.
- `req_ready`=0 in every non-IDLE state; requests are never queued.
- Request inputs are sampled only on the accept edge; later changes are ignored.
- Reset mid-operation aborts with no response. The in-flight op is lost, and `mul_L`=1 re-parks the multiplier.
- A `req_valid` deassertion before grant is allowed; no grant is recorded.

Optional Feature:
- Macro `MUL_SCHED_ZERO_BYPASS_EN`.
- Defined: on an accept where either operand is 0, skip LOAD/RUN/CAPT and go directly to RESP with `rsp_data`=0. `rsp_valid` rises 1 cycle after the accept edge, and the multiplier stays parked (`mul_L`=1).
- Undefined: zero operands take the full `MUL_LAT`+3 path and still produce 0.

Test Plan:
- Req0 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> `rsp_data`=0xFFFFFFFE, `rsp_id`=0, `rsp_valid` 67 cycles after accept; `mul_L` high exactly one cycle after accept.
- Req1 MUL a=7, b=0xFFFFFFFD (-3) -> `rsp_data`=0xFFFFFFEB, `rsp_id`=1; MULH with the same operands -> 0xFFFFFFFF.
- MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> 0xFFFFFFFF.
- Both `req_valid` high continuously after reset -> grants in order 0,1,0; `req_ready` never two-hot; no grant while `busy`.
- `rsp_ready` held low 10 cycles in RESP -> `rsp_valid`/`rsp_data` stable, `req_ready`=0; releases on the `rsp_ready` edge.
- `Rst` pulsed low during RUN cycle 20 -> immediate IDLE, `rsp_valid` never asserts, `mul_L`=1. A following MUL 3*5 -> 15.
- With `MUL_SCHED_ZERO_BYPASS_EN`: MUL a=0, b=123 -> `rsp_data`=0 one cycle after accept, `mul_L` never drops.
